// File: rtl/ysyx_22041211_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory-port arbiter.
// States, owner ids and one-hot grant codes.
package ysyx_22041211_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_IFU  = 2'b01;
  localparam logic [1:0] GNT_LSU  = 2'b10;

endpackage

// File: rtl/ysyx_22041211_arb_pick.sv
// Two-way round-robin pick: on a tie the requester
// that did not own the port last time wins.
module ysyx_22041211_arb_pick
  import ysyx_22041211_mem_arbiter_pkg::*;
(
  input  logic       ifu_valid,
  input  logic       lsu_valid,
  input  owner_t     last_owner,
  output logic [1:0] grant
);

  always_comb begin
    grant = GNT_NONE;
    priority case (1'b1)
      (ifu_valid && lsu_valid):
        grant = (last_owner == OWNER_IFU) ? GNT_LSU : GNT_IFU;
      ifu_valid: grant = GNT_IFU;
      lsu_valid: grant = GNT_LSU;
      default:   grant = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Shares one memory port between fetch and load/store.
// Define YSYX_22041211_ARB_TIMEOUT_EN to abort stalled transactions.
module ysyx_22041211_mem_arbiter
  import ysyx_22041211_mem_arbiter_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_LEN-1:0]   ifu_addr,
  output logic                  ifu_rsp_valid,
  output logic [DATA_LEN-1:0]   ifu_rsp_data,
  output logic                  ifu_rsp_err,
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic [ADDR_LEN-1:0]   lsu_addr,
  input  logic                  lsu_wen,
  input  logic [DATA_LEN-1:0]   lsu_wdata,
  input  logic [DATA_LEN/8-1:0] lsu_wmask,
  output logic                  lsu_rsp_valid,
  output logic [DATA_LEN-1:0]   lsu_rsp_data,
  output logic                  lsu_rsp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_LEN-1:0]   mem_addr,
  output logic                  mem_wen,
  output logic [DATA_LEN-1:0]   mem_wdata,
  output logic [DATA_LEN/8-1:0] mem_wmask,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_LEN-1:0]   mem_rsp_data,
  input  logic                  mem_rsp_err,
  output logic                  busy
);

  localparam int MW = DATA_LEN / 8;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t         state;
  state_t         state_nx;
  owner_t         last_owner;
  owner_t         owner;
  logic [1:0]     grant;
  logic           ifu_gnt;
  logic           lsu_gnt;
  logic           rsp_fire;
  logic           tmo_fire;
  logic           done;
  logic           rsp_err_w;
  logic [DATA_LEN-1:0] rsp_data_w;

  ysyx_22041211_arb_pick u_pick (
    .ifu_valid  (ifu_req_valid),
    .lsu_valid  (lsu_req_valid),
    .last_owner (last_owner),
    .grant      (grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    ifu_gnt       = 1'b0;
    lsu_gnt       = 1'b0;
    mem_req_valid = 1'b0;
    rsp_fire      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // Ready is forced low while reset is held.
        if (!rst) begin
          ifu_gnt = grant[0];
          lsu_gnt = grant[1];
        end
        if (ifu_gnt || lsu_gnt) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        mem_req_valid = 1'b1;
        if (tmo_fire)           state_nx = ST_IDLE;
        else if (mem_req_ready) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        rsp_fire = mem_rsp_valid;
        if (rsp_fire || tmo_fire) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWNER_IFU;
      owner      <= OWNER_IFU;
      mem_addr   <= '0;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else if (ifu_gnt) begin
      last_owner <= OWNER_IFU;
      owner      <= OWNER_IFU;
      mem_addr   <= ifu_addr;
      mem_wen    <= 1'b0;
      mem_wdata  <= '0;
      mem_wmask  <= {MW{1'b1}};
    end else if (lsu_gnt) begin
      last_owner <= OWNER_LSU;
      owner      <= OWNER_LSU;
      mem_addr   <= lsu_addr;
      mem_wen    <= lsu_wen;
      mem_wdata  <= lsu_wdata;
      mem_wmask  <= lsu_wmask;
    end
  end

`ifdef YSYX_22041211_ARB_TIMEOUT_EN
  localparam int CW =
    (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (ifu_gnt | lsu_gnt) cnt <= '0;
    else if (state != ST_IDLE)  cnt <= cnt + CW'(1);
  end

  // cnt lags elapsed cycles by one; a real response wins a tie.
  assign tmo_fire = (state != ST_IDLE)
                 && (cnt == CW'(TIMEOUT - 1))
                 && !(state == ST_WAIT && mem_rsp_valid);
`else
  assign tmo_fire = 1'b0;
`endif

  assign done       = rsp_fire | tmo_fire;
  assign rsp_data_w = rsp_fire ? mem_rsp_data : '0;
  assign rsp_err_w  = rsp_fire ? mem_rsp_err : tmo_fire;

  assign ifu_req_ready = ifu_gnt;
  assign lsu_req_ready = lsu_gnt;

  assign ifu_rsp_valid = done && (owner == OWNER_IFU);
  assign ifu_rsp_data  = ifu_rsp_valid ? rsp_data_w : '0;
  assign ifu_rsp_err   = ifu_rsp_valid & rsp_err_w;

  assign lsu_rsp_valid = done && (owner == OWNER_LSU);
  assign lsu_rsp_data  = lsu_rsp_valid ? rsp_data_w : '0;
  assign lsu_rsp_err   = lsu_rsp_valid & rsp_err_w;

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Directed bench for the IFU/LSU memory arbiter.
// Timeout steps run only with YSYX_22041211_ARB_TIMEOUT_EN.
module tb_ysyx_22041211_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_data;
  logic        ifu_rsp_err;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rsp_data;
  logic        lsu_rsp_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  ysyx_22041211_mem_arbiter #(
    .ADDR_LEN (32),
    .DATA_LEN (32),
    .TIMEOUT  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req_valid (ifu_req_valid),
    .ifu_req_ready (ifu_req_ready),
    .ifu_addr      (ifu_addr),
    .ifu_rsp_valid (ifu_rsp_valid),
    .ifu_rsp_data  (ifu_rsp_data),
    .ifu_rsp_err   (ifu_rsp_err),
    .lsu_req_valid (lsu_req_valid),
    .lsu_req_ready (lsu_req_ready),
    .lsu_addr      (lsu_addr),
    .lsu_wen       (lsu_wen),
    .lsu_wdata     (lsu_wdata),
    .lsu_wmask     (lsu_wmask),
    .lsu_rsp_valid (lsu_rsp_valid),
    .lsu_rsp_data  (lsu_rsp_data),
    .lsu_rsp_err   (lsu_rsp_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_wen       (mem_wen),
    .mem_wdata     (mem_wdata),
    .mem_wmask     (mem_wmask),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .busy          (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving.
  task automatic settle();
    #2;
  endtask

  initial begin
    rst           = 1'b1;
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h0;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h0;
    lsu_wen       = 1'b0;
    lsu_wdata     = 32'h0;
    lsu_wmask     = 4'h0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    mem_rsp_err   = 1'b0;
    settle();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ifu_ready", 32'(ifu_req_ready), 32'd0);
    chk("rst_lsu_ready", 32'(lsu_req_ready), 32'd0);
    chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wmask", 32'(mem_wmask), 32'h0);
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    tick();
    rst = 1'b0;

    // IFU-only fetch
    tick();
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    mem_req_ready = 1'b1;
    settle();
    chk("f_ifu_ready", 32'(ifu_req_ready), 32'd1);
    chk("f_lsu_ready", 32'(lsu_req_ready), 32'd0);
    tick();
    ifu_req_valid = 1'b0;
    settle();
    chk("f_mem_valid", 32'(mem_req_valid), 32'd1);
    chk("f_mem_addr", mem_addr, 32'h8000_0000);
    chk("f_mem_wmask", 32'(mem_wmask), 32'hF);
    chk("f_mem_wen", 32'(mem_wen), 32'd0);
    chk("f_busy", 32'(busy), 32'd1);
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0010_0093;
    settle();
    chk("f_ifu_rsp_v", 32'(ifu_rsp_valid), 32'd1);
    chk("f_ifu_rsp_d", ifu_rsp_data, 32'h0010_0093);
    chk("f_ifu_rsp_e", 32'(ifu_rsp_err), 32'd0);
    chk("f_lsu_rsp_v", 32'(lsu_rsp_valid), 32'd0);
    chk("f_lsu_rsp_d", lsu_rsp_data, 32'h0);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("f_ifu_rsp_off", 32'(ifu_rsp_valid), 32'd0);
    chk("f_ifu_data_off", ifu_rsp_data, 32'h0);
    chk("f_idle", 32'(busy), 32'd0);

    // Tie: last owner IFU, so LSU wins, then IFU
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0004;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_1000;
    lsu_wen       = 1'b0;
    lsu_wmask     = 4'hF;
    settle();
    chk("t_lsu_ready", 32'(lsu_req_ready), 32'd1);
    chk("t_ifu_ready", 32'(ifu_req_ready), 32'd0);
    tick();
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    chk("t_mem_addr1", mem_addr, 32'h8000_1000);
    chk("t_ifu_blocked", 32'(ifu_req_ready), 32'd0);
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1122_3344;
    settle();
    chk("t_lsu_rsp_v", 32'(lsu_rsp_valid), 32'd1);
    chk("t_lsu_rsp_d", lsu_rsp_data, 32'h1122_3344);
    chk("t_ifu_rsp_v", 32'(ifu_rsp_valid), 32'd0);
    chk("t_no_grant_rsp", 32'(ifu_req_ready), 32'd0);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("t_ifu_ready2", 32'(ifu_req_ready), 32'd1);
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    settle();
    chk("t_mem_addr2", mem_addr, 32'h8000_0004);
    chk("t_mem_wmask2", 32'(mem_wmask), 32'hF);
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hAABB_CCDD;
    mem_rsp_err   = 1'b1;
    settle();
    chk("t_ifu_rsp_v2", 32'(ifu_rsp_valid), 32'd1);
    chk("t_ifu_rsp_d2", ifu_rsp_data, 32'hAABB_CCDD);
    chk("t_ifu_rsp_e2", 32'(ifu_rsp_err), 32'd1);
    chk("t_lsu_rsp_v2", 32'(lsu_rsp_valid), 32'd0);
    tick();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;

    // LSU store with 3 stall cycles
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_2000;
    lsu_wen       = 1'b1;
    lsu_wdata     = 32'hDEAD_BEEF;
    lsu_wmask     = 4'b0011;
    settle();
    chk("s_lsu_ready", 32'(lsu_req_ready), 32'd1);
    tick();
    lsu_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
      end
      settle();
      chk("s_mem_valid", 32'(mem_req_valid), 32'd1);
      chk("s_mem_addr", mem_addr, 32'h8000_2000);
      chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("s_mem_wmask", 32'(mem_wmask), 32'h3);
      chk("s_mem_wen", 32'(mem_wen), 32'd1);
      chk("s_busy", 32'(busy), 32'd1);
      chk("s_no_rsp", 32'(lsu_rsp_valid), 32'd0);
      tick();
    end
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    settle();
    chk("s_wait_busy", 32'(busy), 32'd1);
    chk("s_wait_noreq", 32'(mem_req_valid), 32'd0);
    chk("s_wait_norsp", 32'(lsu_rsp_valid), 32'd0);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h0;
    settle();
    chk("s_lsu_rsp_v", 32'(lsu_rsp_valid), 32'd1);
    chk("s_lsu_rsp_e", 32'(lsu_rsp_err), 32'd0);
    chk("s_ifu_rsp_v", 32'(ifu_rsp_valid), 32'd0);
    tick();

    // Spurious response in IDLE
    mem_rsp_data = 32'h5555_5555;
    settle();
    chk("sp_ifu_rsp", 32'(ifu_rsp_valid), 32'd0);
    chk("sp_lsu_rsp", 32'(lsu_rsp_valid), 32'd0);
    chk("sp_lsu_data", lsu_rsp_data, 32'h0);
    tick();
    mem_rsp_valid = 1'b0;
    settle();
    chk("sp_idle", 32'(busy), 32'd0);

    // Reset in WAIT drops the transaction
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0008;
    settle();
    chk("r_ifu_ready", 32'(ifu_req_ready), 32'd1);
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    settle();
    chk("r_wait_busy", 32'(busy), 32'd1);
    rst           = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h1234_5678;
    settle();
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_mem_addr", mem_addr, 32'h0);
    chk("r_mem_wmask", 32'(mem_wmask), 32'h0);
    chk("r_ifu_rsp", 32'(ifu_rsp_valid), 32'd0);
    chk("r_ifu_data", ifu_rsp_data, 32'h0);
    tick();
    rst = 1'b0;
    settle();
    chk("r_late_rsp", 32'(ifu_rsp_valid), 32'd0);
    tick();
    mem_rsp_valid = 1'b0;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    lsu_addr      = 32'h8000_3000;
    settle();
    chk("r_tie_lsu", 32'(lsu_req_ready), 32'd1);
    chk("r_tie_ifu", 32'(ifu_req_ready), 32'd0);
    tick();
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    settle();
    chk("r_lsu_rsp", 32'(lsu_rsp_valid), 32'd1);
    tick();
    mem_rsp_valid = 1'b0;

`ifdef YSYX_22041211_ARB_TIMEOUT_EN
    // Timeout with TIMEOUT=4
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_000C;
    settle();
    chk("to_grant", 32'(ifu_req_ready), 32'd1);
    tick();
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      settle();
      chk("to_pending", 32'(ifu_rsp_valid), 32'd0);
      tick();
      mem_req_ready = 1'b0;
    end
    settle();
    chk("to_rsp_v", 32'(ifu_rsp_valid), 32'd1);
    chk("to_rsp_e", 32'(ifu_rsp_err), 32'd1);
    chk("to_rsp_d", ifu_rsp_data, 32'h0);
    tick();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFE_F00D;
    settle();
    chk("to_late", 32'(ifu_rsp_valid), 32'd0);
    chk("to_idle", 32'(busy), 32'd0);
    tick();
    mem_rsp_valid = 1'b0;
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
